// File: rtl/cache_drain_unit.sv
// Drain sequencer for the MEM stage: once the store buffer is empty, walks every
// data-cache line and writes each valid+dirty line back to memory, then clears its dirty bit.
module cache_drain_unit #(
  parameter int NUM_LINES = 4,
  parameter int LINE_W    = 128,
  parameter int IDX_W     = $clog2(NUM_LINES),
  parameter int TAG_W     = 32 - IDX_W - 4
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              drain_req,
  input  logic              sb_empty,
  output logic              drain_busy,
  output logic              drain_done,
  output logic [IDX_W-1:0]  rd_index,
  input  logic              rd_valid,
  input  logic              rd_dirty,
  input  logic [TAG_W-1:0]  rd_tag,
  input  logic [LINE_W-1:0] rd_data,
  output logic              clr_dirty,
  output logic [IDX_W-1:0]  clr_index,
  output logic              mem_req,
  output logic [31:0]       mem_addr,
  output logic [LINE_W-1:0] mem_wdata,
  input  logic              mem_ready,
  output logic [IDX_W:0]    lines_written
);

  typedef enum logic [2:0] {
    IDLE, WAIT_SB, READ, CHECK, WRITE, CLEAR, DONE, REARM
  } state_t;

  state_t              state, state_nxt;
  logic [IDX_W-1:0]    idx;
  logic [IDX_W:0]      lines_written_q;
  logic [31:0]         mem_addr_q;
  logic [LINE_W-1:0]   mem_wdata_q;

  logic start, hit, last, advance;

  assign start   = (state == IDLE) && drain_req;
  assign hit     = rd_valid && rd_dirty;
  assign last    = (idx == IDX_W'(NUM_LINES - 1));
  assign advance = ((state == CHECK) && !hit) || (state == CLEAR);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state           <= IDLE;
      idx             <= '0;
      lines_written_q <= '0;
      mem_addr_q      <= '0;
      mem_wdata_q     <= '0;
    end else begin
      state <= state_nxt;
      if (start) begin
        idx             <= '0;
        lines_written_q <= '0;
      end else if (advance && !last) begin
        idx <= idx + 1'b1;
      end
      if ((state == CHECK) && hit) begin
        mem_addr_q  <= {rd_tag, idx, 4'b0000};
        mem_wdata_q <= rd_data;
      end
      if ((state == WRITE) && mem_ready)
        lines_written_q <= lines_written_q + 1'b1;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (drain_req) state_nxt = WAIT_SB;
      WAIT_SB: if (sb_empty) state_nxt = READ;
      READ:    state_nxt = CHECK;
      CHECK:   if (hit) state_nxt = WRITE;
               else     state_nxt = last ? DONE : READ;
      WRITE:   if (mem_ready) state_nxt = CLEAR;
      CLEAR:   state_nxt = last ? DONE : READ;
      DONE:    state_nxt = REARM;
      REARM:   if (!drain_req) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // The stall is released in the same cycle the completion pulse fires.
  always_comb begin
    drain_busy = 1'b0;
    case (state)
      WAIT_SB, READ, CHECK, WRITE, CLEAR: drain_busy = 1'b1;
      default:                            drain_busy = 1'b0;
    endcase
  end

  assign drain_done    = (state == DONE);
  assign clr_dirty     = (state == CLEAR);
  assign mem_req       = (state == WRITE);
  assign rd_index      = idx;
  assign clr_index     = idx;
  assign mem_addr      = mem_addr_q;
  assign mem_wdata     = mem_wdata_q;
  assign lines_written = lines_written_q;

endmodule

// File: tb/tb_cache_drain_unit.sv
// Directed bench for cache_drain_unit: a registered-read cache model, a memory
// responder with programmable stall, and one task per scenario.
module tb_cache_drain_unit;

  localparam int IDX_W = 2;
  localparam int TAG_W = 26;

  logic              clock, reset;
  logic              drain_req, sb_empty;
  logic              drain_busy, drain_done;
  logic [IDX_W-1:0]  rd_index;
  logic              rd_valid, rd_dirty;
  logic [TAG_W-1:0]  rd_tag;
  logic [127:0]      rd_data;
  logic              clr_dirty;
  logic [IDX_W-1:0]  clr_index;
  logic              mem_req;
  logic [31:0]       mem_addr;
  logic [127:0]      mem_wdata;
  logic              mem_ready;
  logic [IDX_W:0]    lines_written;

  int checks = 0;
  int errors = 0;

  cache_drain_unit dut (
    .clock(clock), .reset(reset), .drain_req(drain_req), .sb_empty(sb_empty),
    .drain_busy(drain_busy), .drain_done(drain_done), .rd_index(rd_index),
    .rd_valid(rd_valid), .rd_dirty(rd_dirty), .rd_tag(rd_tag), .rd_data(rd_data),
    .clr_dirty(clr_dirty), .clr_index(clr_index), .mem_req(mem_req),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_ready(mem_ready),
    .lines_written(lines_written)
  );

  // clock / reset
  initial clock = 1'b0;
  always #5 clock = ~clock;

  // cache model: contents configured by the tests, dirty bits owned here
  logic [3:0]       cfg_valid, cfg_dirty, mdirty;
  logic [TAG_W-1:0] cfg_tag [4];
  logic [127:0]     cfg_data [4];
  logic             cfg_load;

  always @(posedge clock) begin
    rd_valid <= cfg_valid[rd_index];
    rd_dirty <= mdirty[rd_index];
    rd_tag   <= cfg_tag[rd_index];
    rd_data  <= cfg_data[rd_index];
    if (cfg_load) mdirty <= cfg_dirty;
    else if (clr_dirty) mdirty[clr_index] <= 1'b0;
  end

  // memory responder: ready after mem_stall cycles of a held request
  int mem_stall;
  int stall_cnt;
  assign mem_ready = mem_req && (stall_cnt >= mem_stall);

  always @(posedge clock) begin
    if (!reset) stall_cnt <= 0;
    else if (mem_req && !mem_ready) stall_cnt <= stall_cnt + 1;
    else stall_cnt <= 0;
  end

  // monitor: logs accepted writes, clears, done pulses and unstable stalled writes
  logic [31:0]  wr_addr_log [16];
  logic [127:0] wr_data_log [16];
  logic [1:0]   clr_idx_log [16];
  int wr_cnt = 0, clr_cnt = 0, done_cnt = 0, stable_err = 0;
  logic         prev_req = 1'b0;
  logic [31:0]  prev_addr = '0;
  logic [127:0] prev_data = '0;

  always @(negedge clock) begin
    if (mem_req && mem_ready) begin
      wr_addr_log[wr_cnt & 15] <= mem_addr;
      wr_data_log[wr_cnt & 15] <= mem_wdata;
      wr_cnt <= wr_cnt + 1;
    end
    if (clr_dirty) begin
      clr_idx_log[clr_cnt & 15] <= clr_index;
      clr_cnt <= clr_cnt + 1;
    end
    if (drain_done) done_cnt <= done_cnt + 1;
    if (mem_req && prev_req && (mem_addr != prev_addr || mem_wdata != prev_data))
      stable_err <= stable_err + 1;
    prev_req  <= mem_req;
    prev_addr <= mem_addr;
    prev_data <= mem_wdata;
  end

  // driver tasks
  task automatic load_cache();
    @(negedge clock);
    cfg_load = 1'b1;
    @(negedge clock);
    cfg_load = 1'b0;
  endtask

  task automatic all_clean();
    cfg_valid = 4'b1111;
    cfg_dirty = 4'b0000;
    for (int i = 0; i < 4; i++) begin
      cfg_tag[i]  = TAG_W'(i + 1);
      cfg_data[i] = {96'h0, 32'(i * 16 + 3)};
    end
  endtask

  // Raises drain_req and counts cycles (posedges) until drain_done is seen.
  task automatic run_drain(input int sb_delay, input int max_cyc,
                           output int done_at, output int busy_bad);
    @(negedge clock);
    drain_req = 1'b1;
    sb_empty  = (sb_delay == 0);
    done_at   = -1;
    busy_bad  = 0;
    for (int n = 1; n <= max_cyc && done_at < 0; n++) begin
      @(posedge clock);
      @(negedge clock);
      if (drain_done) begin
        done_at = n;
        if (drain_busy) busy_bad++;
      end else if (!drain_busy) begin
        busy_bad++;
      end
      if (sb_delay != 0 && n == sb_delay) sb_empty = 1'b1;
    end
  endtask

  task automatic end_drain();
    drain_req = 1'b0;
    @(negedge clock);
    @(negedge clock);
  endtask

  task automatic test_reset();
    reset = 1'b0;
    #1;
    checks++; if (drain_busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", drain_busy); end
    checks++; if (drain_done !== 1'b0) begin errors++; $display("FAIL reset_done got %b want 0", drain_done); end
    checks++; if (mem_req !== 1'b0) begin errors++; $display("FAIL reset_mem_req got %b want 0", mem_req); end
    checks++; if (clr_dirty !== 1'b0) begin errors++; $display("FAIL reset_clr got %b want 0", clr_dirty); end
    checks++; if (mem_addr !== 32'h0) begin errors++; $display("FAIL reset_addr got %h want 0", mem_addr); end
    checks++; if (mem_wdata !== 128'h0) begin errors++; $display("FAIL reset_wdata got %h want 0", mem_wdata); end
    checks++; if (rd_index !== 2'd0 || clr_index !== 2'd0) begin errors++; $display("FAIL reset_index got %0d/%0d want 0/0", rd_index, clr_index); end
    checks++; if (lines_written !== 3'd0) begin errors++; $display("FAIL reset_lines got %0d want 0", lines_written); end
    repeat (3) @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
  endtask

  task automatic test_all_clean();
    int done_at, busy_bad, w0;
    all_clean();
    load_cache();
    w0 = wr_cnt;
    run_drain(0, 40, done_at, busy_bad);
    checks++; if (done_at != 10) begin errors++; $display("FAIL clean_done_cycle got %0d want 10", done_at); end
    checks++; if (busy_bad != 0) begin errors++; $display("FAIL clean_busy bad_cycles %0d want 0", busy_bad); end
    checks++; if (wr_cnt - w0 != 0) begin errors++; $display("FAIL clean_writes got %0d want 0", wr_cnt - w0); end
    checks++; if (lines_written !== 3'd0) begin errors++; $display("FAIL clean_lines got %0d want 0", lines_written); end
    end_drain();
  endtask

  task automatic test_one_dirty();
    int done_at, busy_bad, w0, c0;
    logic [127:0] d1;
    d1 = 128'h0000_0000_0000_0000_0000_0005_0000_000A;
    all_clean();
    cfg_valid   = 4'b1011;  // line 2 invalid but marked dirty: must be skipped
    cfg_dirty   = 4'b0110;
    cfg_tag[1]  = '0;
    cfg_data[1] = d1;
    load_cache();
    mem_stall = 0;
    w0 = wr_cnt; c0 = clr_cnt;
    run_drain(0, 40, done_at, busy_bad);
    checks++; if (done_at != 12) begin errors++; $display("FAIL one_done_cycle got %0d want 12", done_at); end
    checks++; if (wr_cnt - w0 != 1) begin errors++; $display("FAIL one_writes got %0d want 1", wr_cnt - w0); end
    checks++; if (wr_addr_log[w0 & 15] !== 32'h10) begin errors++; $display("FAIL one_addr got %h want 00000010", wr_addr_log[w0 & 15]); end
    checks++; if (wr_data_log[w0 & 15] !== d1) begin errors++; $display("FAIL one_data got %h want %h", wr_data_log[w0 & 15], d1); end
    checks++; if (clr_cnt - c0 != 1 || clr_idx_log[c0 & 15] !== 2'd1) begin errors++; $display("FAIL one_clear got n=%0d idx=%0d want n=1 idx=1", clr_cnt - c0, clr_idx_log[c0 & 15]); end
    checks++; if (lines_written !== 3'd1) begin errors++; $display("FAIL one_lines got %0d want 1", lines_written); end
    checks++; if (mdirty !== 4'b0100) begin errors++; $display("FAIL one_dirty_bits got %b want 0100", mdirty); end
    end_drain();
  endtask

  task automatic test_stall();
    int done_at, busy_bad, w0, s0;
    logic [127:0] d0, d3;
    d0 = 128'h1111_2222_3333_4444_5555_6666_7777_8888;
    d3 = 128'hDEAD_BEEF_0000_0001_CAFE_F00D_0000_0003;
    all_clean();
    cfg_dirty   = 4'b1001;
    cfg_tag[0]  = TAG_W'(5);   // {5, 0, 0} = 0x140
    cfg_tag[3]  = TAG_W'(8);   // {8, 3, 0} = 0x230
    cfg_data[0] = d0;
    cfg_data[3] = d3;
    load_cache();
    mem_stall = 3;
    w0 = wr_cnt; s0 = stable_err;
    run_drain(0, 60, done_at, busy_bad);
    checks++; if (done_at != 20) begin errors++; $display("FAIL stall_done_cycle got %0d want 20", done_at); end
    checks++; if (wr_cnt - w0 != 2) begin errors++; $display("FAIL stall_writes got %0d want 2", wr_cnt - w0); end
    checks++; if (wr_addr_log[w0 & 15] !== 32'h140 || wr_data_log[w0 & 15] !== d0) begin errors++; $display("FAIL stall_first got %h/%h want 00000140/%h", wr_addr_log[w0 & 15], wr_data_log[w0 & 15], d0); end
    checks++; if (wr_addr_log[(w0 + 1) & 15] !== 32'h230 || wr_data_log[(w0 + 1) & 15] !== d3) begin errors++; $display("FAIL stall_second got %h/%h want 00000230/%h", wr_addr_log[(w0 + 1) & 15], wr_data_log[(w0 + 1) & 15], d3); end
    checks++; if (stable_err - s0 != 0) begin errors++; $display("FAIL stall_stable got %0d changes want 0", stable_err - s0); end
    checks++; if (busy_bad != 0) begin errors++; $display("FAIL stall_busy bad_cycles %0d want 0", busy_bad); end
    checks++; if (lines_written !== 3'd2) begin errors++; $display("FAIL stall_lines got %0d want 2", lines_written); end
    mem_stall = 0;
    end_drain();
  endtask

  task automatic test_sb_wait();
    int done_at, busy_bad;
    all_clean();
    load_cache();
    // sb_empty rises after the 6th edge: 5 extra WAIT_SB cycles
    run_drain(6, 60, done_at, busy_bad);
    checks++; if (done_at != 15) begin errors++; $display("FAIL sbwait_done_cycle got %0d want 15", done_at); end
    checks++; if (busy_bad != 0) begin errors++; $display("FAIL sbwait_busy bad_cycles %0d want 0", busy_bad); end
    end_drain();
  endtask

  task automatic test_held_req();
    int done_at, busy_bad, d0;
    all_clean();
    load_cache();
    d0 = done_cnt;
    run_drain(0, 40, done_at, busy_bad);
    repeat (20) @(negedge clock);
    checks++; if (done_cnt - d0 != 1) begin errors++; $display("FAIL held_done_pulses got %0d want 1", done_cnt - d0); end
    checks++; if (drain_busy !== 1'b0) begin errors++; $display("FAIL held_busy got %b want 0", drain_busy); end
    end_drain();
    run_drain(0, 40, done_at, busy_bad);
    checks++; if (done_at != 10) begin errors++; $display("FAIL held_rearm_cycle got %0d want 10", done_at); end
    end_drain();
  endtask

  task automatic test_reset_mid();
    int done_at, busy_bad, w0, n;
    all_clean();
    cfg_dirty  = 4'b0100;
    cfg_tag[2] = TAG_W'(3);    // {3, 2, 0} = 0xE0
    load_cache();
    mem_stall = 1000;
    w0 = wr_cnt;
    @(negedge clock);
    drain_req = 1'b1;
    sb_empty  = 1'b1;
    n = 0;
    while (!mem_req && n < 40) begin
      @(negedge clock);
      n++;
    end
    checks++; if (mem_req !== 1'b1 || rd_index !== 2'd2) begin errors++; $display("FAIL rstmid_reach_write got req=%b idx=%0d want req=1 idx=2", mem_req, rd_index); end
    #2 reset = 1'b0;
    #1;
    checks++; if (mem_req !== 1'b0 || drain_busy !== 1'b0) begin errors++; $display("FAIL rstmid_async got req=%b busy=%b want 0/0", mem_req, drain_busy); end
    checks++; if (lines_written !== 3'd0 || mem_addr !== 32'h0) begin errors++; $display("FAIL rstmid_outputs got lines=%0d addr=%h want 0/0", lines_written, mem_addr); end
    drain_req = 1'b0;
    mem_stall = 0;
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    checks++; if (wr_cnt - w0 != 0 || mdirty !== 4'b0100) begin errors++; $display("FAIL rstmid_abandon got writes=%0d dirty=%b want 0/0100", wr_cnt - w0, mdirty); end
    run_drain(0, 40, done_at, busy_bad);
    checks++; if (done_at != 12) begin errors++; $display("FAIL rstmid_restart_cycle got %0d want 12", done_at); end
    checks++; if (wr_cnt - w0 != 1 || wr_addr_log[w0 & 15] !== 32'hE0) begin errors++; $display("FAIL rstmid_restart_write got n=%0d addr=%h want 1/000000e0", wr_cnt - w0, wr_addr_log[w0 & 15]); end
    checks++; if (lines_written !== 3'd1 || mdirty !== 4'b0000) begin errors++; $display("FAIL rstmid_restart_state got lines=%0d dirty=%b want 1/0000", lines_written, mdirty); end
    end_drain();
  endtask

  initial begin
    drain_req = 1'b0;
    sb_empty  = 1'b1;
    cfg_load  = 1'b0;
    mem_stall = 0;
    all_clean();
    test_reset();
    test_all_clean();
    test_one_dirty();
    test_stall();
    test_sb_wait();
    test_held_req();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
